// File: rtl/ifmap_pkt_pkg.sv
// Shared definitions for the ifmap NoC packet receiver.
//   DATA_TYPE_IFMAP : packet type code carried by ifmap packets
//   ifmap_pkt_t     : field layout of a 32-bit ifmap packet
//   ifmap_state_e   : row reassembly FSM states
//   hdr_ok()        : header acceptance predicate for a given PE id
package ifmap_pkt_pkg;

    localparam logic [1:0]  DATA_TYPE_IFMAP = 2'b01;

    // dst[7:3] addresses the PE, dst[2:0] is the sub-row tag
    localparam int unsigned DST_PE_LSB = 3;
    localparam int unsigned TAG_W      = 3;
    localparam int unsigned PE_W       = 5;

    typedef struct packed {
        logic        rsvd;
        logic [1:0]  dtype;
        logic [7:0]  dst;
        logic [7:0]  seg;
        logic [12:0] payload;
    } ifmap_pkt_t;

    typedef enum logic {
        IDLE,
        WAIT_SEG1
    } ifmap_state_e;

    function automatic logic hdr_ok(input ifmap_pkt_t p, input logic [PE_W-1:0] pe_id);
        return (p.rsvd == 1'b0) && (p.dtype == DATA_TYPE_IFMAP) &&
               (p.dst[7:DST_PE_LSB] == pe_id) && (p.seg[7:1] == 7'd0);
    endfunction

endpackage

// File: rtl/row_fifo2.sv
// Two-entry in-order FIFO with the head held in its own register so the
// output data comes straight from a flop.
//   clk_i, rst_ni        : clock, synchronous active-low reset
//   in_valid_i/in_ready_o: write handshake (ready whenever not full)
//   in_data_i            : entry to write
//   out_valid_o/out_ready_i : read handshake
//   out_data_o           : head entry
module row_fifo2 #(
    parameter int unsigned DW = 28
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o
);

    logic [DW-1:0] head_q, head_d;
    logic [DW-1:0] tail_q, tail_d;
    logic [1:0]    count_q, count_d;
    logic          push, pop;

    assign in_ready_o  = (count_q != 2'd2);
    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = head_q;
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case (count_q)
            2'd0: begin
                if (push) begin
                    head_d  = in_data_i;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_d = in_data_i;
                end else if (push) begin
                    tail_d  = in_data_i;
                    count_d = 2'd2;
                end else if (pop) begin
                    count_d = 2'd0;
                end
            end
            2'd2: begin
                // Not ready when full, so only a pop can happen here
                if (pop) begin
                    head_d  = tail_q;
                    count_d = 2'd1;
                end
            end
            default: count_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ifmap_row_unpacker.sv
// PE-side ifmap packet receiver: checks packet headers, rebuilds 25-bit rows
// from two segments and queues them in a 2-entry row FIFO.
//   clk, rst_n           : clock, synchronous active-low reset
//   pkt_valid/pkt_ready  : packet handshake from the router local port
//   pkt_data             : {rsvd, type, dst, seg, payload}
//   row_valid/row_ready  : row handshake toward the PE datapath
//   row_data, row_tag    : reassembled row and its sub-row index
//   rows_done            : rows popped, wrapping
//   err_cnt              : dropped/aborted packets, saturating
module ifmap_row_unpacker
    import ifmap_pkt_pkg::*;
#(
    parameter int unsigned PKT_W   = 32,
    parameter int unsigned SEG_W   = 13,
    parameter int unsigned WIDTH_I = 25,
    parameter logic [4:0]  PE_ID   = 5'd1,
    parameter int unsigned ERR_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pkt_valid,
    output logic               pkt_ready,
    input  logic [PKT_W-1:0]   pkt_data,
    output logic               row_valid,
    input  logic               row_ready,
    output logic [WIDTH_I-1:0] row_data,
    output logic [TAG_W-1:0]   row_tag,
    output logic [7:0]         rows_done,
    output logic [ERR_W-1:0]   err_cnt
);

    localparam int unsigned HiW    = WIDTH_I - SEG_W;
    localparam int unsigned FifoW  = TAG_W + WIDTH_I;

    ifmap_pkt_t   pkt;
    ifmap_state_e state_q, state_d;
    logic [SEG_W-1:0] low_q, low_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [ERR_W-1:0] err_q;
    logic [7:0]       rows_q;

    logic accept, hdr_good, is_seg0, tag_match;
    logic push, err_inc;
    logic fifo_in_ready;
    logic [FifoW-1:0] fifo_in, fifo_out;
    logic unused_payload_msb;

    assign pkt       = ifmap_pkt_t'(pkt_data);
    assign accept    = pkt_valid && pkt_ready;
    assign hdr_good  = hdr_ok(pkt, PE_ID);
    assign is_seg0   = (pkt.seg[0] == 1'b0);
    assign tag_match = (pkt.dst[TAG_W-1:0] == tag_q);

    // The top payload bit of segment 1 carries no row data
    assign unused_payload_msb = pkt.payload[SEG_W-1];

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            low_q   <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            low_q   <= low_d;
            tag_q   <= tag_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        low_d   = low_q;
        tag_d   = tag_q;
        if (accept && hdr_good) begin
            case (state_q)
                IDLE: begin
                    if (is_seg0) begin
                        low_d   = pkt.payload[SEG_W-1:0];
                        tag_d   = pkt.dst[TAG_W-1:0];
                        state_d = WAIT_SEG1;
                    end
                end
                WAIT_SEG1: begin
                    if (is_seg0) begin
                        // New seg 0 restarts the row; the old partial is lost
                        low_d = pkt.payload[SEG_W-1:0];
                        tag_d = pkt.dst[TAG_W-1:0];
                    end else if (tag_match) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs
    always_comb begin
        pkt_ready = !((state_q == WAIT_SEG1) && !fifo_in_ready);
        push      = 1'b0;
        err_inc   = 1'b0;
        if (accept) begin
            if (!hdr_good) begin
                err_inc = 1'b1;
            end else begin
                case (state_q)
                    IDLE:      err_inc = !is_seg0;
                    WAIT_SEG1: begin
                        if (is_seg0 || !tag_match) begin
                            err_inc = 1'b1;
                        end else begin
                            push = 1'b1;
                        end
                    end
                    default: err_inc = 1'b0;
                endcase
            end
        end
    end

    assign fifo_in = {tag_q, pkt.payload[HiW-1:0], low_q};

    row_fifo2 #(
        .DW (FifoW)
    ) u_row_fifo2 (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (push),
        .in_ready_o  (fifo_in_ready),
        .in_data_i   (fifo_in),
        .out_valid_o (row_valid),
        .out_ready_i (row_ready),
        .out_data_o  (fifo_out)
    );

    assign row_data = fifo_out[WIDTH_I-1:0];
    assign row_tag  = fifo_out[FifoW-1:WIDTH_I];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q  <= '0;
            rows_q <= '0;
        end else begin
            if (err_inc && (err_q != {ERR_W{1'b1}})) begin
                err_q <= err_q + 1'b1;
            end
            if (row_valid && row_ready) begin
                rows_q <= rows_q + 8'd1;
            end
        end
    end

    assign err_cnt   = err_q;
    assign rows_done = rows_q;

endmodule

// File: tb/tb_ifmap_row_unpacker.sv
module tb_ifmap_row_unpacker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [31:0] pkt_data;
    logic        row_valid;
    logic        row_ready;
    logic [24:0] row_data;
    logic [2:0]  row_tag;
    logic [7:0]  rows_done;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    ifmap_row_unpacker #(
        .PKT_W   (32),
        .SEG_W   (13),
        .WIDTH_I (25),
        .PE_ID   (5'd1),
        .ERR_W   (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pkt_valid (pkt_valid),
        .pkt_ready (pkt_ready),
        .pkt_data  (pkt_data),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .row_data  (row_data),
        .row_tag   (row_tag),
        .rows_done (rows_done),
        .err_cnt   (err_cnt)
    );

    int checks   = 0;
    int failures = 0;

    // Scoreboard of expected {tag, row}, oldest first
    logic [27:0] sb[$];
    int          popped = 0;

    // Reference model: a pending half-row and an error tally
    bit          m_has_low = 0;
    logic [12:0] m_low     = '0;
    logic [2:0]  m_tag     = '0;
    int          m_err     = 0;

    bit rr_rand = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic rsvd, input logic [1:0] ty,
                                       input logic [7:0] dst, input logic [7:0] seg,
                                       input logic [12:0] pl);
        return {rsvd, ty, dst, seg, pl};
    endfunction

    function automatic void model_err();
        if (m_err < 255) m_err++;
    endfunction

    // Apply one accepted packet to the model
    function automatic void model_accept(input logic [31:0] p);
        logic [7:0]  dst;
        logic [7:0]  seg;
        logic [12:0] pl;
        int          row;
        dst = p[28:21];
        seg = p[20:13];
        pl  = p[12:0];
        if (p[31] != 1'b0 || p[30:29] != 2'b01 || dst[7:3] != 5'd1 || seg > 8'd1) begin
            model_err();
        end else if (seg == 8'd0) begin
            if (m_has_low) model_err();
            m_has_low = 1;
            m_low     = pl;
            m_tag     = dst[2:0];
        end else if (m_has_low && m_tag == dst[2:0]) begin
            row = int'(pl[11:0]) * 8192 + int'(m_low);
            sb.push_back({m_tag, row[24:0]});
            m_has_low = 0;
        end else begin
            model_err();
        end
    endfunction

    task automatic send_pkt(input logic [31:0] p, input int bound);
        bit ok;
        ok = 0;
        @(posedge clk);
        #1;
        pkt_valid = 1'b1;
        pkt_data  = p;
        for (int c = 0; c < bound; c++) begin
            @(negedge clk);
            if (pkt_ready) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL send_timeout: got pkt_ready=0 expected 1 within %0d cycles", bound);
            pkt_valid = 1'b0;
        end else begin
            model_accept(p);
            @(posedge clk);
            #1;
            pkt_valid = 1'b0;
        end
    endtask

    task automatic send_row(input logic [2:0] tag, input logic [24:0] row);
        send_pkt(mk(1'b0, 2'b01, {5'd1, tag}, 8'd0, row[12:0]), 50);
        send_pkt(mk(1'b0, 2'b01, {5'd1, tag}, 8'd1, {1'($urandom_range(0, 1)), row[24:13]}), 50);
    endtask

    task automatic drain(input int bound);
        bit ok;
        ok = 0;
        @(posedge clk);
        #1;
        row_ready = 1'b1;
        for (int c = 0; c < bound; c++) begin
            @(negedge clk);
            if (sb.size() == 0 && !row_valid) begin
                ok = 1;
                break;
            end
        end
        chk("drain_done", {31'd0, ok}, 32'd1);
        @(posedge clk);
        #1;
        row_ready = 1'b0;
    endtask

    // Monitor: compare every popped row against the scoreboard head
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && row_valid && row_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_row", {4'd0, row_tag, row_data}, 32'hFFFF_FFFF);
                end else begin
                    chk("row", {4'd0, row_tag, row_data}, {4'd0, sb.pop_front()});
                end
                popped++;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rr_rand) row_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic check_reset_outputs();
        @(negedge clk);
        chk("rst_row_valid", {31'd0, row_valid}, 32'd0);
        chk("rst_row_data", {7'd0, row_data}, 32'd0);
        chk("rst_row_tag", {29'd0, row_tag}, 32'd0);
        chk("rst_rows_done", {24'd0, rows_done}, 32'd0);
        chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        chk("rst_pkt_ready", {31'd0, pkt_ready}, 32'd1);
    endtask

    int base_rows;

    initial begin
        rst_n     = 1'b0;
        pkt_valid = 1'b0;
        pkt_data  = '0;
        row_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_reset_outputs();

        // Basic row and one-cycle latency
        send_pkt(32'h21001555, 50);
        send_pkt(32'h21003AAA, 50);
        @(negedge clk);
        chk("basic_valid", {31'd0, row_valid}, 32'd1);
        chk("basic_data", {7'd0, row_data}, 32'h1555555);
        chk("basic_tag", {29'd0, row_tag}, 32'd0);
        chk("basic_err", {24'd0, err_cnt}, 32'd0);
        drain(20);
        chk("basic_rows_done", {24'd0, rows_done}, 32'd1);

        // Tagged rows, boundary payloads
        base_rows = popped;
        send_row(3'd3, 25'h1FFFFFF);
        send_row(3'd3, 25'h0000001);
        drain(20);
        chk("tag_rows_done", {24'd0, rows_done}, 32'(base_rows + 2));

        // Header rejects
        send_pkt(32'h41001555, 50);
        send_pkt(32'h21101555, 50);
        send_pkt(32'h22001555, 50);
        send_pkt(32'h21004000, 50);
        send_pkt(32'hA1001555, 50);
        @(negedge clk);
        chk("reject_err", {24'd0, err_cnt}, 32'd5);
        chk("reject_norow", {31'd0, row_valid}, 32'd0);

        // Sequencing errors
        send_pkt(mk(1'b0, 2'b01, 8'h08, 8'd1, 13'h0123), 50);
        chk("seg1_idle_err", {24'd0, err_cnt}, 32'd6);
        send_pkt(mk(1'b0, 2'b01, 8'h08, 8'd0, 13'h1234), 50);
        send_pkt(mk(1'b0, 2'b01, 8'h08, 8'd0, 13'h0001), 50);
        send_pkt(mk(1'b0, 2'b01, 8'h09, 8'd1, 13'h0FFF), 50);
        send_pkt(mk(1'b0, 2'b01, 8'h08, 8'd1, 13'h0FFF), 50);
        @(negedge clk);
        chk("seq_err", {24'd0, err_cnt}, 32'd8);
        chk("seq_row", {7'd0, row_data}, 32'h1FFE001);
        drain(20);

        // Backpressure: two rows fill the FIFO, third row stalls on seg 1
        send_row(3'd1, 25'h0ABCDEF);
        send_row(3'd2, 25'h1234567);
        send_pkt(mk(1'b0, 2'b01, 8'h0D, 8'd0, 13'h1111), 50);
        @(negedge clk);
        chk("bp_stall", {31'd0, pkt_ready}, 32'd0);
        @(posedge clk);
        #1;
        pkt_valid = 1'b1;
        pkt_data  = mk(1'b0, 2'b01, 8'h0D, 8'd1, 13'h0222);
        row_ready = 1'b1;
        @(negedge clk);
        chk("bp_still_stall", {31'd0, pkt_ready}, 32'd0);
        @(posedge clk);
        #1;
        row_ready = 1'b0;
        @(negedge clk);
        chk("bp_release", {31'd0, pkt_ready}, 32'd1);
        model_accept(pkt_data);
        @(posedge clk);
        #1;
        pkt_valid = 1'b0;
        @(negedge clk);
        chk("bp_err", {24'd0, err_cnt}, 32'(m_err));
        drain(20);

        // Randomized traffic with random consumer backpressure
        rr_rand = 1;
        for (int i = 0; i < 300; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 6) begin
                send_row(3'($urandom_range(0, 7)), 25'($urandom));
            end else if (r < 8) begin
                send_pkt(mk(1'b0, 2'b01, {5'd1, 3'($urandom_range(0, 7))},
                            8'($urandom_range(0, 1)), 13'($urandom)), 50);
            end else begin
                send_pkt($urandom, 50);
            end
        end
        rr_rand = 0;
        drain(50);
        chk("rand_err", {24'd0, err_cnt}, 32'(m_err));
        chk("rand_rows_done", {24'd0, rows_done}, 32'(popped % 256));

        // Reset with one row queued and a half row pending
        row_ready = 1'b0;
        send_row(3'd4, 25'h0F0F0F0);
        send_pkt(mk(1'b0, 2'b01, 8'h0C, 8'd0, 13'h0AAA), 50);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        sb.delete();
        popped    = 0;
        m_has_low = 0;
        m_err     = 0;
        check_reset_outputs();
        send_pkt(mk(1'b0, 2'b01, 8'h0C, 8'd1, 13'h0555), 50);
        @(negedge clk);
        chk("post_rst_err", {24'd0, err_cnt}, 32'd1);
        chk("post_rst_norow", {31'd0, row_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
